up_pwm: RTL and testbench

PWM generator that sits directly downstream of the 4-bit synchronous up counter and consumes its `count_out` bus as a free-running timebase. A duty value is loaded through a valid/ready handshake into a pending register and applied glitch-free at the next counter wrap. The block also emits a period-start pulse, counts completed periods, and flags any illegal step in the incoming count sequence.

---
 rtl/up_pwm.sv | 134 +++++++++++++
 tb/tb_up_pwm.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/up_pwm.sv
`default_nettype none
// ============================================================================
//  Module      : up_pwm
//  Description : PWM generator driven by an external free-running up-count
//                timebase. A duty value is accepted over a valid/ready
//                handshake into a one-deep pending slot. It is promoted to the
//                active duty at the next counter wrap, so a period is never
//                cut short or stretched. The block also emits a period-start
//                pulse, counts completed periods and latches a sticky error
//                when the incoming count makes an illegal step.
//
//  Ports
//    clk          in   1        rising-edge clock
//    reset        in   1        asynchronous active-high reset
//    count_in     in   WIDTH    upstream counter value
//    duty_in      in   WIDTH+1  requested high time per period (clamped)
//    duty_valid   in   1        duty_in offered
//    duty_ready   out  1        pending slot empty
//    pwm_out      out  1        registered PWM output
//    period_start out  1        one-cycle pulse per detected wrap
//    period_cnt   out  PCNT_W   completed periods, modulo 2^PCNT_W
//    seq_err      out  1        sticky illegal-step flag
//
//  Revision    : 1.0 - initial release
// ============================================================================
module up_pwm #(
  parameter int WIDTH  = 4,
  parameter int PCNT_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  count_in,
  input  logic [WIDTH:0]    duty_in,
  input  logic              duty_valid,
  output logic              duty_ready,
  output logic              pwm_out,
  output logic              period_start,
  output logic [PCNT_W-1:0] period_cnt,
  output logic              seq_err
);

  localparam logic [WIDTH-1:0]  c_CNT_MAX  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]  c_CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]  c_CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH:0]    c_DUTY_MAX = {1'b1, {WIDTH{1'b0}}};
  localparam logic [PCNT_W-1:0] c_PCNT_ONE = {{(PCNT_W-1){1'b0}}, 1'b1};

  // Registered state
  logic [WIDTH-1:0]  prev_cnt_q,     prev_cnt_d;
  logic              prev_vld_q,     prev_vld_d;
  logic [WIDTH:0]    duty_act_q,     duty_act_d;
  logic [WIDTH:0]    duty_pend_q,    duty_pend_d;
  logic              pend_full_q,    pend_full_d;
  logic              pwm_q,          pwm_d;
  logic              period_start_q, period_start_d;
  logic [PCNT_W-1:0] period_cnt_q,   period_cnt_d;
  logic              seq_err_q,      seq_err_d;

  // Combinational helpers
  logic              w_wrap;
  logic              w_xfer;
  logic              w_promote;
  logic              w_step_ok;
  logic [WIDTH-1:0]  w_prev_inc;
  logic [WIDTH:0]    w_duty_clamped;
  logic [WIDTH:0]    w_duty_eff;

  always_comb begin
    w_prev_inc     = prev_cnt_q + c_CNT_ONE;
    w_wrap         = prev_vld_q && (prev_cnt_q == c_CNT_MAX) && (count_in == c_CNT_ZERO);
    w_xfer         = duty_valid && !pend_full_q;
    w_promote      = w_wrap && pend_full_q;
    w_step_ok      = (count_in == prev_cnt_q) || (count_in == w_prev_inc);
    w_duty_clamped = (duty_in > c_DUTY_MAX) ? c_DUTY_MAX : duty_in;
    // On the wrap that promotes a pending duty, the new value must already
    // govern the count==0 sample so the first cycle of the period is correct.
    w_duty_eff     = w_promote ? duty_pend_q : duty_act_q;
  end

  always_comb begin
    prev_cnt_d     = count_in;
    prev_vld_d     = 1'b1;
    duty_act_d     = duty_act_q;
    duty_pend_d    = duty_pend_q;
    pend_full_d    = pend_full_q;
    pwm_d          = ({1'b0, count_in} < w_duty_eff);
    period_start_d = w_wrap;
    period_cnt_d   = w_wrap ? (period_cnt_q + c_PCNT_ONE) : period_cnt_q;
    seq_err_d      = seq_err_q || (prev_vld_q && !w_step_ok);

    if (w_promote) begin
      duty_act_d  = duty_pend_q;
      pend_full_d = 1'b0;
    end
    // A transfer needs an empty slot, so it never collides with a promotion;
    // a transfer on a plain wrap cycle waits for the following wrap.
    if (w_xfer) begin
      duty_pend_d = w_duty_clamped;
      pend_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_cnt_q     <= c_CNT_ZERO;
      prev_vld_q     <= 1'b0;
      duty_act_q     <= '0;
      duty_pend_q    <= '0;
      pend_full_q    <= 1'b0;
      pwm_q          <= 1'b0;
      period_start_q <= 1'b0;
      period_cnt_q   <= '0;
      seq_err_q      <= 1'b0;
    end else begin
      prev_cnt_q     <= prev_cnt_d;
      prev_vld_q     <= prev_vld_d;
      duty_act_q     <= duty_act_d;
      duty_pend_q    <= duty_pend_d;
      pend_full_q    <= pend_full_d;
      pwm_q          <= pwm_d;
      period_start_q <= period_start_d;
      period_cnt_q   <= period_cnt_d;
      seq_err_q      <= seq_err_d;
    end
  end

  assign duty_ready   = !pend_full_q;
  assign pwm_out      = pwm_q;
  assign period_start = period_start_q;
  assign period_cnt   = period_cnt_q;
  assign seq_err      = seq_err_q;

endmodule
`default_nettype wire

// File: tb/tb_up_pwm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_up_pwm
//  Description : Directed self-checking bench for up_pwm. Drives a 0..15
//                timebase, writes duties at chosen counts and compares the
//                per-period PWM pattern, pulses, period count, handshake and
//                error flag with hand-computed values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_up_pwm;

  localparam int c_WIDTH  = 4;
  localparam int c_PCNT_W = 8;

  logic                clk;
  logic                reset;
  logic [c_WIDTH-1:0]  count_in;
  logic [c_WIDTH:0]    duty_in;
  logic                duty_valid;
  logic                duty_ready;
  logic                pwm_out;
  logic                period_start;
  logic [c_PCNT_W-1:0] period_cnt;
  logic                seq_err;

  int n_checks;
  int n_fail;

  up_pwm #(.WIDTH(c_WIDTH), .PCNT_W(c_PCNT_W)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .count_in     (count_in),
    .duty_in      (duty_in),
    .duty_valid   (duty_valid),
    .duty_ready   (duty_ready),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .period_cnt   (period_cnt),
    .seq_err      (seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one count (and optional duty offer) at the falling edge, then
  // return 1 ns after the rising edge that sampled it.
  task automatic tick(input logic [3:0] c, input logic dv, input logic [4:0] d);
    @(negedge clk);
    count_in   = c;
    duty_valid = dv;
    duty_in    = d;
    @(posedge clk);
    #1;
  endtask

  // One full period of counts 0..15. Up to two duty offers at given counts
  // (-1 = none). Returns the PWM pattern (bit c = output for count c), the
  // number of period_start pulses, and duty_ready after count 0 and count 15.
  task automatic run_period(input int wr_at, input logic [4:0] d,
                            input int wr2_at, input logic [4:0] d2,
                            output logic [15:0] mask, output int ps,
                            output logic rdy0, output logic rdy_end);
    mask = '0;
    ps   = 0;
    rdy0 = 1'b0;
    for (int c = 0; c < 16; c++) begin
      if (c == wr_at)       tick(4'(c), 1'b1, d);
      else if (c == wr2_at) tick(4'(c), 1'b1, d2);
      else                  tick(4'(c), 1'b0, 5'd0);
      mask[c] = pwm_out;
      if (period_start) ps++;
      if (c == 0) rdy0 = duty_ready;
    end
    rdy_end = duty_ready;
  endtask

  typedef struct {
    string       name;
    int          wr_at;
    logic [4:0]  d;
    int          wr2_at;
    logic [4:0]  d2;
    logic [15:0] exp_mask;
    int          exp_ps;
    logic        exp_rdy0;
    logic        exp_rdy_end;
    int          exp_pcnt;
  } period_vec_t;

  period_vec_t vecs[8];

  initial begin
    logic [15:0] mask;
    int          ps;
    int          ps_total;
    logic        rdy0;
    logic        rdy_end;

    n_checks   = 0;
    n_fail     = 0;
    reset      = 1'b1;
    count_in   = '0;
    duty_in    = '0;
    duty_valid = 1'b0;

    // Period table: A is the first period after reset (no wrap into it).
    vecs[0] = '{"A_wr4",    7, 5'd4,  -1, 5'd0, 16'h0000, 0, 1'b1, 1'b0, 0};
    vecs[1] = '{"B_duty4", -1, 5'd0,  -1, 5'd0, 16'h000F, 1, 1'b1, 1'b1, 1};
    vecs[2] = '{"C_wr0",    7, 5'd0,  -1, 5'd0, 16'h000F, 1, 1'b1, 1'b0, 2};
    vecs[3] = '{"D_wr16",   7, 5'd16, -1, 5'd0, 16'h0000, 1, 1'b1, 1'b0, 3};
    vecs[4] = '{"E_wr31",   7, 5'd31, -1, 5'd0, 16'hFFFF, 1, 1'b1, 1'b0, 4};
    vecs[5] = '{"F_wr8_2",  7, 5'd8,  10, 5'd2, 16'hFFFF, 1, 1'b1, 1'b0, 5};
    vecs[6] = '{"G_duty8", -1, 5'd0,  -1, 5'd0, 16'h00FF, 1, 1'b1, 1'b1, 6};
    vecs[7] = '{"H_duty8", -1, 5'd0,  -1, 5'd0, 16'h00FF, 1, 1'b1, 1'b1, 7};

    // Reset held with count 0
    #100;
    check("rst_pwm",   32'(pwm_out),      32'd0);
    check("rst_ready", 32'(duty_ready),   32'd1);
    check("rst_err",   32'(seq_err),      32'd0);
    check("rst_pcnt",  32'(period_cnt),   32'd0);
    check("rst_ps",    32'(period_start), 32'd0);
    #100;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(4'd0, 1'b0, 5'd0);
      check("hold0_pwm",   32'(pwm_out),    32'd0);
      check("hold0_ready", 32'(duty_ready), 32'd1);
      check("hold0_err",   32'(seq_err),    32'd0);
      check("hold0_pcnt",  32'(period_cnt), 32'd0);
    end

    // Duty loading, clamping and ignored offers while the slot is full
    foreach (vecs[i]) begin
      run_period(vecs[i].wr_at, vecs[i].d, vecs[i].wr2_at, vecs[i].d2,
                 mask, ps, rdy0, rdy_end);
      check({vecs[i].name, "_mask"},    32'(mask),       32'(vecs[i].exp_mask));
      check({vecs[i].name, "_ps"},      32'(ps),         32'(vecs[i].exp_ps));
      check({vecs[i].name, "_rdy0"},    32'(rdy0),       32'(vecs[i].exp_rdy0));
      check({vecs[i].name, "_rdy_end"}, 32'(rdy_end),    32'(vecs[i].exp_rdy_end));
      check({vecs[i].name, "_pcnt"},    32'(period_cnt), 32'(vecs[i].exp_pcnt));
      check({vecs[i].name, "_err"},     32'(seq_err),    32'd0);
    end

    // Sequence check: 0..5, hold 5, 6, then illegal jump to 8
    tick(4'd0, 1'b0, 5'd0);
    check("seq_wrap_ps",   32'(period_start), 32'd1);
    check("seq_wrap_pcnt", 32'(period_cnt),   32'd8);
    for (int c = 1; c <= 5; c++) tick(4'(c), 1'b0, 5'd0);
    tick(4'd5, 1'b0, 5'd0);
    check("seq_hold_err", 32'(seq_err), 32'd0);
    tick(4'd6, 1'b0, 5'd0);
    check("seq_inc_err", 32'(seq_err), 32'd0);
    tick(4'd8, 1'b0, 5'd0);
    check("seq_jump_err", 32'(seq_err), 32'd1);
    for (int c = 9; c <= 15; c++) tick(4'(c), 1'b0, 5'd0);
    check("seq_sticky_err", 32'(seq_err), 32'd1);

    // 300 periods: 8 + 300 = 308 -> 52 modulo 256
    ps_total = 0;
    for (int p = 0; p < 300; p++) begin
      run_period(-1, 5'd0, -1, 5'd0, mask, ps, rdy0, rdy_end);
      ps_total += ps;
    end
    check("long_ps_total", 32'(ps_total),   32'd300);
    check("long_pcnt",     32'(period_cnt), 32'd52);
    check("long_mask",     32'(mask),       32'h00FF);
    check("long_err",      32'(seq_err),    32'd1);

    // Next period: wrap -> 53, write duty 12 at count 5, reset at count 9
    for (int c = 0; c <= 9; c++) tick(4'(c), (c == 5), 5'd12);
    check("pre_rst_pcnt",  32'(period_cnt), 32'd53);
    check("pre_rst_ready", 32'(duty_ready), 32'd0);
    reset = 1'b1;
    #1;
    check("async_rst_pwm",   32'(pwm_out),      32'd0);
    check("async_rst_ready", 32'(duty_ready),   32'd1);
    check("async_rst_pcnt",  32'(period_cnt),   32'd0);
    check("async_rst_err",   32'(seq_err),      32'd0);
    check("async_rst_ps",    32'(period_start), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Pending 12 was discarded: output stays low across the next period
    mask = '0;
    for (int c = 10; c <= 15; c++) begin
      tick(4'(c), 1'b0, 5'd0);
      mask[c] = pwm_out;
    end
    run_period(-1, 5'd0, -1, 5'd0, mask, ps, rdy0, rdy_end);
    check("post_rst_mask", 32'(mask),       32'h0000);
    check("post_rst_ps",   32'(ps),         32'd1);
    check("post_rst_pcnt", 32'(period_cnt), 32'd1);
    check("post_rst_err",  32'(seq_err),    32'd0);
    check("post_rst_rdy",  32'(rdy_end),    32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
